// File: rtl/seg_pkg.sv
// Shared definitions for the 4-digit 7-segment scanner: FSM encodings,
// segment glyphs and the segDrivers field layout.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2,
        ST_OFF   = 2'd3
    } state_e;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int SEG_LSB  = 0;
    localparam int SEG_W    = 7;
    localparam int DSEL_LSB = 7;
    localparam int DSEL_W   = 4;
    localparam int DRV_W    = DSEL_W + SEG_W;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] seg_hex(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Nibble to 7-segment glyph; in BCD mode the non-decimal codes show a dash.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hexMode,
    output logic [6:0] seg
);

    always_comb begin
        if (!hexMode && nibble > 4'd9) seg = SEG_DASH;
        else                           seg = seg_hex(nibble);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scanner: per-slot blanking, PWM brightness,
// frame-synchronous shadowing of the displayed value, leading-zero blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 27000000,
    parameter int SCAN_HZ      = 2700,
    parameter int BLANK_CYCLES = 27,
    parameter int HEX_MODE     = 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [15:0]      number,
    input  logic             colonEnable,
    input  logic             zeroBlank,
    input  logic [2:0]       brightness,
    output logic [DRV_W-1:0] segDrivers,
    output logic             colonOut,
    output logic             frameDone
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int PW    = $clog2(DWELL);
    localparam int ACT   = DWELL - BLANK_CYCLES;
    localparam int PRW   = PW + 3;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [PW-1:0] on_end_q, on_end_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   num_q, num_d;
    logic          col_sh_q, col_sh_d;
    logic          zb_q, zb_d;
    logic [3:0]    dsel_q, dsel_d;
    logic [6:0]    seg_q, seg_d;
    logic          colon_q, colon_d;

    logic           slot_end;
    logic [PRW-1:0] on_prod;
    logic [PW-1:0]  on_end_new;
    logic [3:0]     nib;
    logic           lead_zero;
    logic [6:0]     dec_seg;

    assign slot_end = (presc_q == PW'(DWELL - 1));

    // Last prescaler value of the lit window; the product is widened so the
    // multiply by (brightness+1) cannot overflow before the divide by 8.
    assign on_prod    = PRW'(ACT) * PRW'({1'b0, brightness} + 4'd1);
    assign on_end_new = PW'(BLANK_CYCLES) + on_prod[PRW-1:3] - PW'(1);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            on_end_q <= '0;
            idx_q    <= '0;
            num_q    <= '0;
            col_sh_q <= 1'b0;
            zb_q     <= 1'b0;
            dsel_q   <= '0;
            seg_q    <= '0;
            colon_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            on_end_q <= on_end_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            col_sh_q <= col_sh_d;
            zb_q     <= zb_d;
            dsel_q   <= dsel_d;
            seg_q    <= seg_d;
            colon_q  <= colon_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        on_end_d = on_end_q;
        num_d    = num_q;
        col_sh_d = col_sh_q;
        zb_d     = zb_q;
        case (state_q)
            ST_IDLE: state_d = ST_BLANK;
            ST_BLANK: begin
                if (presc_q == PW'(BLANK_CYCLES - 1)) begin
                    state_d  = ST_DRIVE;
                    on_end_d = on_end_new;
                end
            end
            ST_DRIVE: begin
                if (slot_end) begin
                    state_d = ST_BLANK;
                    idx_d   = idx_q + 2'd1;
                end else if (presc_q == on_end_q) begin
                    state_d = ST_OFF;
                end
            end
            ST_OFF: begin
                if (slot_end) begin
                    state_d = ST_BLANK;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        presc_d = (state_q == ST_IDLE || slot_end) ? '0 : presc_q + PW'(1);
        // Shadow inputs only at frame start so a frame never mixes two values.
        if (state_d == ST_BLANK && state_q != ST_BLANK && idx_d == 2'd0) begin
            num_d    = number;
            col_sh_d = colonEnable;
            zb_d     = zeroBlank;
        end
    end

    always_comb begin
        case (idx_d)
            2'd0:    nib = num_q[3:0];
            2'd1:    nib = num_q[7:4];
            2'd2:    nib = num_q[11:8];
            default: nib = num_q[15:12];
        endcase
        case (idx_d)
            2'd1:    lead_zero = (num_q[15:4] == 12'd0);
            2'd2:    lead_zero = (num_q[15:8] == 8'd0);
            2'd3:    lead_zero = (num_q[15:12] == 4'd0);
            default: lead_zero = 1'b0;
        endcase
    end

    seg_decode u_dec (
        .nibble  (nib),
        .hexMode (HEX_MODE != 0),
        .seg     (dec_seg)
    );

    // Outputs are computed from the next state and registered, so they switch
    // exactly on state entry and cannot glitch between digits.
    always_comb begin
        dsel_d  = '0;
        seg_d   = SEG_BLANK;
        colon_d = 1'b0;
        if (state_d == ST_DRIVE) begin
            dsel_d  = 4'b0001 << idx_d;
            seg_d   = (zb_q && lead_zero) ? SEG_BLANK : dec_seg;
            colon_d = col_sh_q && (idx_d == 2'd1);
        end
    end

    assign segDrivers[DSEL_LSB +: DSEL_W] = dsel_q;
    assign segDrivers[SEG_LSB +: SEG_W]   = seg_q;
    assign colonOut  = colon_q;
    assign frameDone = slot_end && (idx_q == 2'd3) &&
                       (state_q == ST_DRIVE || state_q == ST_OFF);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: expected digit episodes are queued per frame and checked
// as each lit digit window ends, for a hex and a BCD instance side by side.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstN;
    logic [15:0] number;
    logic        colonEnable, zeroBlank;
    logic [2:0]  brightness;
    logic [10:0] sd_h, sd_b;
    logic        co_h, co_b, fd_h, fd_b;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(10), .BLANK_CYCLES(4), .HEX_MODE(1)) dut_h (
        .clk(clk), .rstN(rstN), .number(number), .colonEnable(colonEnable),
        .zeroBlank(zeroBlank), .brightness(brightness),
        .segDrivers(sd_h), .colonOut(co_h), .frameDone(fd_h)
    );

    seg_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(10), .BLANK_CYCLES(4), .HEX_MODE(0)) dut_b (
        .clk(clk), .rstN(rstN), .number(number), .colonEnable(colonEnable),
        .zeroBlank(zeroBlank), .brightness(brightness),
        .segDrivers(sd_b), .colonOut(co_b), .frameDone(fd_b)
    );

    typedef struct {
        logic [3:0] d;
        logic [6:0] s;
        logic       c;
        int         len;
        int         gap;
    } ep_t;

    ep_t qh[$];
    ep_t qb[$];
    int  checks = 0;
    int  fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] pat(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    // DWELL=100, BLANK=4: lit window is 96*(b+1)/8, the rest of the slot is dark.
    function automatic void push_frame(input logic [15:0] num, input logic col,
                                       input logic zb, input logic [2:0] b, input bit first);
        ep_t        e;
        int         on;
        logic [3:0] n;
        logic       lz;
        on = (96 * (int'(b) + 1)) / 8;
        for (int k = 0; k < 4; k++) begin
            n     = num[k*4 +: 4];
            lz    = zb && (k != 0) && ((num >> (4*k)) == 16'd0);
            e.d   = 4'b0001 << k;
            e.c   = col && (k == 1);
            e.len = on;
            e.gap = (first && k == 0) ? 5 : 100 - on;
            e.s   = lz ? 7'h00 : pat(n);
            qh.push_back(e);
            e.s   = lz ? 7'h00 : ((n > 4'd9) ? 7'h40 : pat(n));
            qb.push_back(e);
        end
    endfunction

    logic [10:0] sdv [2];
    logic        cov [2];
    assign sdv[0] = sd_h;
    assign sdv[1] = sd_b;
    assign cov[0] = co_h;
    assign cov[1] = co_b;

    bit         in_ep [2];
    bit         stab  [2];
    logic [3:0] cd    [2];
    logic [6:0] cs    [2];
    logic       cc    [2];
    int         len   [2];
    int         zeros [2];
    int         gap   [2];

    task automatic end_ep(input int i);
        ep_t   e;
        string p;
        int    sz;
        p  = (i == 0) ? "hex" : "bcd";
        sz = (i == 0) ? qh.size() : qb.size();
        if (sz == 0) begin
            chk({p, "_unexpected_digit"}, 32'(sz), 32'd1);
            return;
        end
        if (i == 0) e = qh.pop_front();
        else        e = qb.pop_front();
        chk({p, "_dsel"},   32'(cd[i]),   32'(e.d));
        chk({p, "_seg"},    32'(cs[i]),   32'(e.s));
        chk({p, "_colon"},  32'(cc[i]),   32'(e.c));
        chk({p, "_on_len"}, 32'(len[i]),  32'(e.len));
        chk({p, "_gap"},    32'(gap[i]),  32'(e.gap));
        chk({p, "_stable"}, 32'(stab[i]), 32'd1);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstN) begin
                in_ep[i] = 1'b0;
                zeros[i] = 0;
            end else begin
                if (in_ep[i] && sdv[i][10:7] != cd[i]) begin
                    end_ep(i);
                    in_ep[i] = 1'b0;
                    zeros[i] = 0;
                end
                if (!in_ep[i]) begin
                    if (sdv[i][10:7] != 4'd0) begin
                        in_ep[i] = 1'b1;
                        cd[i]    = sdv[i][10:7];
                        cs[i]    = sdv[i][6:0];
                        cc[i]    = cov[i];
                        len[i]   = 1;
                        stab[i]  = 1'b1;
                        gap[i]   = zeros[i];
                    end else begin
                        zeros[i]++;
                    end
                end else begin
                    len[i]++;
                    if (sdv[i][6:0] != cs[i] || cov[i] != cc[i]) stab[i] = 1'b0;
                end
            end
        end
    end

    int fd_cnt, fd_next, fd_seen;
    always @(negedge clk) begin
        if (!rstN) begin
            fd_cnt  = 0;
            fd_next = 401;
            fd_seen = 0;
        end else begin
            fd_cnt++;
            if (fd_h) begin
                chk("frame_done_cycle", 32'(fd_cnt), 32'(fd_next));
                fd_next += 400;
                fd_seen++;
            end
        end
    end

    task automatic scen(input logic [15:0] num, input logic col, input logic zb,
                        input logic [2:0] b, input int frames, input bit chg,
                        input logic [15:0] nn);
        bit done;
        number      = num;
        colonEnable = col;
        zeroBlank   = zb;
        brightness  = b;
        push_frame(num, col, zb, b, 1'b1);
        for (int f = 1; f < frames; f++) push_frame(chg ? nn : num, col, zb, b, 1'b0);
        @(posedge clk); #1;
        rstN = 1'b1;
        done = 1'b0;
        repeat (400 * frames + 3) begin
            @(posedge clk); #1;
            if (chg && !done && sd_h[10:7] == 4'b0010) begin
                number = nn;
                done   = 1'b1;
            end
        end
        if (chg) chk("mid_frame_change_applied", 32'(done), 32'd1);
        chk("hex_sb_left", 32'(qh.size()), 32'd0);
        chk("bcd_sb_left", 32'(qb.size()), 32'd0);
        chk("frame_done_count", 32'(fd_seen), 32'(frames));
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        qh.delete();
        qb.delete();
    endtask

    initial begin
        int t;
        rstN        = 1'b0;
        number      = 16'h0;
        colonEnable = 1'b0;
        zeroBlank   = 1'b0;
        brightness  = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg_hex", 32'(sd_h), 32'd0);
        chk("rst_seg_bcd", 32'(sd_b), 32'd0);
        chk("rst_colon",   32'(co_h), 32'd0);
        chk("rst_frame",   32'(fd_h), 32'd0);

        scen(16'h12AF, 1'b0, 1'b0, 3'd7, 2, 1'b0, 16'h0);
        scen(16'h00A5, 1'b1, 1'b1, 3'd7, 1, 1'b0, 16'h0);
        scen(16'h0000, 1'b0, 1'b1, 3'd0, 1, 1'b0, 16'h0);
        scen(16'h0305, 1'b0, 1'b1, 3'd3, 1, 1'b0, 16'h0);
        scen(16'h1111, 1'b0, 1'b0, 3'd5, 2, 1'b1, 16'h2222);

        // Reset pulse while digit 1 is lit with the colon on.
        number      = 16'h12AF;
        colonEnable = 1'b1;
        zeroBlank   = 1'b0;
        brightness  = 3'd7;
        push_frame(16'h12AF, 1'b1, 1'b0, 3'd7, 1'b1);
        @(posedge clk); #1;
        rstN = 1'b1;
        t = 0;
        while (!(sd_h[10:7] == 4'b0010 && co_h) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wait_digit1_drive", 32'(sd_h[10:7]), 32'h2);
        chk("colon_before_rst",  32'(co_h),       32'd1);
        rstN = 1'b0;
        #1;
        chk("async_rst_seg_hex", 32'(sd_h), 32'd0);
        chk("async_rst_seg_bcd", 32'(sd_b), 32'd0);
        chk("async_rst_colon",   32'(co_h), 32'd0);
        chk("async_rst_frame",   32'(fd_h), 32'd0);
        chk("sb_pending_at_rst", 32'(qh.size()), 32'd3);
        repeat (2) @(posedge clk);
        #1;
        qh.delete();
        qb.delete();

        scen(16'hBEEF, 1'b1, 1'b0, 3'd6, 1, 1'b0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000, input clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_HZ, default 2700, digit-step rate; DWELL = CLK_HZ/SCAN_HZ clock cycles per digit slot.
REQ-003 SHALL have parameter BLANK_CYCLES, default 27, cycles of all-digits-off at the start of each slot; legal range 1..DWELL-9.
REQ-004 SHALL have parameter HEX_MODE, default 1: 1 = hex nibbles; 0 = BCD nibbles, with codes A-F shown as dash.
REQ-005 SHALL run on one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock, rising edge.
REQ-007 rstN  input  1  asynchronous active-low reset.
REQ-008 number  input  16  four nibbles; digit 0 = number[3:0] (rightmost), digit 3 = number[15:12].
REQ-009 colonEnable  input  1  colon request.
REQ-010 zeroBlank  input  1  leading-zero suppression enable.
REQ-011 brightness  input  3  duty level 0..7.
REQ-012 segDrivers  output  11  {digitSel[3:0], seg[6:0]}; seg = {g,f,e,d,c,b,a}; all bits active-high.
REQ-013 colonOut  output  1  colon drive, active-high.
REQ-014 frameDone  output  1  one-cycle pulse at the end of digit-3 slot.

Function
REQ-015 Prescaler SHALL count 0..DWELL-1 and wrap; each wrap SHALL end the current slot.
REQ-016 FSM states SHALL be IDLE, BLANK, DRIVE, OFF. Transitions: IDLE->BLANK on the first cycle after reset release; BLANK->DRIVE when slotCnt == BLANK_CYCLES-1.
REQ-017 DRIVE->OFF when the on-time expires; DRIVE or OFF->BLANK on slot end, with digitIdx incremented modulo 4 (3 wraps to 0).
REQ-018 On-time SHALL be ((DWELL-BLANK_CYCLES)*(brightness+1))/8 cycles; at brightness=7 OFF SHALL never be entered.
REQ-019 In IDLE, BLANK and OFF: digitSel=0, seg=0, colonOut=0.
REQ-020 In DRIVE: digitSel is one-hot bit digitIdx and seg is the decoded nibble, both registered; each changes exactly on state entry, with no glitch between digits.
REQ-021 number, colonEnable and zeroBlank SHALL be latched into shadow registers only on entry to BLANK with digitIdx=0. A mid-frame change SHALL take effect on the next frame (no tearing).
REQ-022 brightness SHALL be sampled at every BLANK->DRIVE transition.
REQ-023 Leading-zero suppression: with zeroBlank=1, digits 3..1 SHALL be blank while they and all higher nibbles are 0. Digit 0 SHALL always show.
REQ-024 colonOut SHALL equal the shadowed colonEnable during DRIVE of digit 1 only.
REQ-025 frameDone SHALL assert for one cycle at the slot-end cycle of digit 3.
REQ-026 All internal counters SHALL be sized by $clog2 of their maximum value; no truncation is allowed for DWELL up to 2^24.

Reset
REQ-027 While rstN=0: state=IDLE, digitIdx=0, prescaler=0, shadow registers=0, segDrivers=0, colonOut=0, frameDone=0.
REQ-028 Reset assertion mid-DRIVE SHALL clear all outputs asynchronously within the same cycle.
REQ-029 After rstN deasserts, the first DRIVE SHALL be digit 0 using the number latched at that frame start.

Structure
REQ-030 A shared package (seg_pkg) SHALL hold the FSM state encodings, the segment patterns (0-F, dash=7'h40, blank=7'h00) and the segDrivers field offsets.
REQ-031 Nibble decode SHALL be a separate combinational sub-module, seg_decode (nibble, hexMode -> seg[6:0]); all other logic stays in seg_scan_ctrl.

Verification
Bench parameters: CLK_HZ=1000, SCAN_HZ=10 (DWELL=100), BLANK_CYCLES=4.
REQ-032 number=16'h12AF, brightness=7, zeroBlank=0 -> digitSel cycles 0001,0010,0100,1000, each on for 96 cycles after 4 blank cycles; seg = 7'h71, 7'h77, 7'h5B, 7'h06; frameDone every 400 cycles.
REQ-033 HEX_MODE=0, number=16'h00A5, zeroBlank=1 -> digits 3 and 2 blank; digit 1 = 7'h40 (dash); digit 0 = 7'h6D.
REQ-034 brightness=0 -> each digit on for exactly 12 cycles, then OFF for 84 cycles; brightness=3 -> on for 48 cycles.
REQ-035 number changed 16'h1111->16'h2222 during digit 1 DRIVE -> digits 2 and 3 of the current frame still show 7'h06; the next frame shows 7'h5B on all digits.
REQ-036 colonEnable=1 -> colonOut high only during digit-1 DRIVE. rstN pulsed low mid-DRIVE -> segDrivers=0 immediately; after release, the first active digit is digit 0 at cycle 4 + 1.
